serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//  A single full-subtractor cell and a stored borrow flop replace a WIDTH-bit ripple chain.
//  Complements the team's full adder (HA/FA) arithmetic cells.
//  Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range is 2 or more.
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a/b are valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      diff/borrow are valid (high only in DONE)
//  out_ready  in   1      consumer accepts the result
//  diff       out  WIDTH  a - b, mod 2^WIDTH
//  borrow     out  1      1 when a < b (unsigned)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; in_ready=1.
//   - out_valid=0, diff=0, borrow=0.
//   - Internal shift registers and bit counter are cleared.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - in_ready=1.
//   - When in_valid && in_ready at an edge: load a/b into shift registers, clear borrow flop
//     and counter, then go to RUN.
//  RUN, one bit per edge:
//   - d = a0 ^ b0 ^ bw.
//   - bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw).
//   - d shifts into the diff register at the MSB end, moving right.
//   - Operand registers shift right.
//   - Counter increments.
//   - On the edge where counter == WIDTH-1 (the last bit): go to DONE and latch borrow = bw_next.
//  DONE:
//   - out_valid=1; diff and borrow are held stable.
//   - When out_ready is high at an edge: go to IDLE.
//   - out_valid drops in the same edge; in_ready rises in the same edge.
//   - diff/borrow keep their last value until the next result completes.
//  Latency:
//   - Accept edge at cycle 0; out_valid is high after edge WIDTH.
//   - Throughput is at most one result per WIDTH+2 cycles (IDLE/DONE are not overlapped).
//  Boundary rules:
//   - in_valid while in RUN or DONE is ignored. in_ready=0 there; no operand capture.
//   - out_ready while not in DONE has no effect.
//   - out_ready held low keeps DONE and out_valid asserted indefinitely (backpressure).
//   - rst_n low mid-RUN or mid-DONE: immediate return to reset values. Partial result is
//     discarded; no out_valid pulse.
//   - Equal operands give diff=0, borrow=0.
//   - Wrap-around: a < b gives 2^WIDTH + a - b with borrow=1.
//  Width rules:
//   - Counter is $clog2(WIDTH) bits.
//   - No signed overflow flag; the consumer interprets diff as signed or unsigned.
// TESTING (WIDTH=8)
//  1 a=0x5A, b=0x23, out_ready=1 -> out_valid high 8 cycles after accept; diff=0x37, borrow=0.
//  2 a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0x80, b=0x7F -> diff=0x01, borrow=0.
//  3 a=0xFF, b=0xFF -> diff=0x00, borrow=0; then back-to-back request a=0x10, b=0x20
//    -> diff=0xF0, borrow=1; in_ready low throughout RUN/DONE.
//  4 out_ready low for 5 cycles after DONE -> out_valid/diff/borrow stable;
//    in_valid pulses with new operands ignored. Then out_ready=1 -> IDLE next edge.
//  5 rst_n asserted at RUN bit 4 -> outputs reset asynchronously, in_ready=1, no out_valid.
//    Next op a=0x33, b=0x11 -> diff=0x22.
//  6 Random 1000 pairs with random out_ready stalls: compare {borrow, diff} to {a<b, a-b}.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b, LSB first.
//
// One full-subtractor cell and a stored borrow flop process one bit per clock.
// Operands are taken in IDLE, WIDTH bits are processed in RUN, and the result
// is held in DONE until the consumer takes it.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b are valid
//   in_ready   operands can be accepted (IDLE only)
//   a          minuend
//   b          subtrahend
//   out_valid  diff/borrow are valid (DONE only)
//   out_ready  consumer accepts the result
//   diff       a - b, mod 2^WIDTH
//   borrow     1 when a < b (unsigned)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sd;
    logic            bw, d, bw_nxt, last, accept;
    logic [CW-1:0]   cnt;

    // Full-subtractor cell on the current LSBs and the stored borrow
    always_comb begin
        d      = sa[0] ^ sb[0] ^ bw;
        bw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
        last   = cnt == CW'(WIDTH - 1);
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // sd collects result bits MSB-first-in so the LSB lands at bit 0 after WIDTH shifts;
    // diff/borrow are separate so they hold the previous result while the next one runs.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            bw  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= {d, sd[WIDTH-1:1]};
            bw  <= bw_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                diff   <= {d, sd[WIDTH-1:1]};
                borrow <= bw_nxt;
            end
        end
endmodule
